vga_param_controller: RTL and testbench

VGA_PARAM_CONTROLLER -- requirements
Module: vga_param_controller

---
 rtl/vga_param_controller_if.sv | 27 ++
 rtl/vga_param_controller.sv | 178 +++++++++++++++++
 tb/tb_vga_param_controller.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_param_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_param_controller_if
// Brief    : Switch input and VGA output bundle of vga_param_controller.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_param_controller_if;
    logic [7:0] sw;
    logic       Hsync;
    logic       Vsync;
    logic [3:0] vgaRed;
    logic [3:0] vgaGreen;
    logic [3:0] vgaBlue;
    logic       video_on;
    logic       frame_start;

    modport master (
        input  sw,
        output Hsync, Vsync, vgaRed, vgaGreen, vgaBlue, video_on, frame_start
    );

    modport slave (
        output sw,
        input  Hsync, Vsync, vgaRed, vgaGreen, vgaBlue, video_on, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_param_controller.sv
`default_nettype none
// ============================================================================
// Module   : vga_param_controller
// Brief    : Parameterised VGA timing generator with solid colour output and
//            optional test patterns (bars / checkerboard / moving bar) enabled
//            by macro VGA_TESTPATTERN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_param_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter int SYNC_POL = 0
) (
    input  wire logic              clk_100Mhz,
    input  wire logic              rst,
    vga_param_controller_if.master vga
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hw      = $clog2(c_h_total);
    localparam int c_vw      = $clog2(c_v_total);
    localparam int c_dw      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_dw-1:0] c_div_last = c_dw'(CLK_DIV - 1);
    localparam logic [c_hw-1:0] c_h_one    = c_hw'(1);
    localparam logic [c_vw-1:0] c_v_one    = c_vw'(1);
    localparam logic [c_dw-1:0] c_d_one    = c_dw'(1);

    localparam logic [31:0] c_h_last  = 32'(c_h_total - 1);
    localparam logic [31:0] c_v_last  = 32'(c_v_total - 1);
    localparam logic [31:0] c_h_act   = 32'(H_ACTIVE);
    localparam logic [31:0] c_v_act   = 32'(V_ACTIVE);
    localparam logic [31:0] c_hs_beg  = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] c_hs_end  = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] c_vs_beg  = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] c_vs_end  = 32'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        c_sync_on = (SYNC_POL != 0);

    logic [c_dw-1:0] r_div;
    logic [c_hw-1:0] r_hcount;
    logic [c_vw-1:0] r_vcount;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_video_on;
    logic            r_frame_start;
    logic [3:0]      r_red;
    logic [3:0]      r_green;
    logic [3:0]      r_blue;

    logic            w_tick;
    logic            w_h_wrap;
    logic            w_v_wrap;
    logic            w_active;
    logic            w_hs_on;
    logic            w_vs_on;
    logic [31:0]     w_h;
    logic [31:0]     w_v;
    logic [2:0]      w_sw_rgb;
    logic [2:0]      w_rgb;

    // Counters are widened to 32 bits so every timing comparison is width-clean.
    assign w_tick   = (r_div == c_div_last);
    assign w_h      = 32'(r_hcount);
    assign w_v      = 32'(r_vcount);
    assign w_h_wrap = (w_h == c_h_last);
    assign w_v_wrap = (w_v == c_v_last);
    assign w_active = (w_h < c_h_act) && (w_v < c_v_act);
    assign w_hs_on  = (w_h >= c_hs_beg) && (w_h < c_hs_end);
    assign w_vs_on  = (w_v >= c_vs_beg) && (w_v < c_vs_end);
    assign w_sw_rgb = {vga.sw[0], vga.sw[2], vga.sw[1]};

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            r_div         <= '0;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= ~c_sync_on;
            r_vsync       <= ~c_sync_on;
            r_video_on    <= 1'b0;
            r_frame_start <= 1'b0;
            r_red         <= 4'h0;
            r_green       <= 4'h0;
            r_blue        <= 4'h0;
        end else begin
            r_frame_start <= 1'b0;
            r_div         <= w_tick ? '0 : r_div + c_d_one;
            if (w_tick) begin
                r_video_on <= w_active;
                r_hsync    <= w_hs_on ? c_sync_on : ~c_sync_on;
                r_vsync    <= w_vs_on ? c_sync_on : ~c_sync_on;
                r_red      <= (w_active && w_rgb[2]) ? 4'hF : 4'h0;
                r_green    <= (w_active && w_rgb[1]) ? 4'hF : 4'h0;
                r_blue     <= (w_active && w_rgb[0]) ? 4'hF : 4'h0;
                if (w_h_wrap) begin
                    r_hcount <= '0;
                    if (w_v_wrap) begin
                        r_vcount      <= '0;
                        r_frame_start <= 1'b1;
                    end else begin
                        r_vcount <= r_vcount + c_v_one;
                    end
                end else begin
                    r_hcount <= r_hcount + c_h_one;
                end
            end
        end
    end

`ifdef VGA_TESTPATTERN_EN
    localparam int c_bar_w = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int c_bw    = (c_bar_w > 1) ? $clog2(c_bar_w) : 1;

    localparam logic [c_bw-1:0] c_bar_last = c_bw'(c_bar_w - 1);
    localparam logic [c_bw-1:0] c_b_one    = c_bw'(1);

    logic [1:0]      r_mode;
    logic [7:0]      r_frame_cnt;
    logic [c_bw-1:0] r_bar_cnt;
    logic [2:0]      r_bar_idx;

    // Mode and frame count change only on the frame wrap, so a whole frame
    // is always drawn with one consistent pattern.
    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            r_mode      <= 2'b00;
            r_frame_cnt <= 8'd0;
            r_bar_cnt   <= '0;
            r_bar_idx   <= 3'd0;
        end else if (w_tick) begin
            if (w_h_wrap) begin
                r_bar_cnt <= '0;
                r_bar_idx <= 3'd0;
                if (w_v_wrap) begin
                    r_mode      <= vga.sw[7:6];
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end else if (r_bar_cnt == c_bar_last) begin
                r_bar_cnt <= '0;
                if (r_bar_idx != 3'd7) begin
                    r_bar_idx <= r_bar_idx + 3'd1;
                end
            end else begin
                r_bar_cnt <= r_bar_cnt + c_b_one;
            end
        end
    end

    always_comb begin
        w_rgb = w_sw_rgb;
        case (r_mode)
            2'b01:   w_rgb = 3'd7 - r_bar_idx;
            2'b10:   w_rgb = (w_h[5] ^ w_v[5]) ? 3'b111 : w_sw_rgb;
            2'b11:   w_rgb = (w_h[9:4] == r_frame_cnt[5:0]) ? 3'b111 : 3'b000;
            default: w_rgb = w_sw_rgb;
        endcase
    end
`else
    assign w_rgb = w_sw_rgb;
`endif

    assign vga.Hsync       = r_hsync;
    assign vga.Vsync       = r_vsync;
    assign vga.vgaRed      = r_red;
    assign vga.vgaGreen    = r_green;
    assign vga.vgaBlue     = r_blue;
    assign vga.video_on    = r_video_on;
    assign vga.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_param_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_param_controller
// Brief    : Directed self-checking bench; instance A is a scaled 80x14 raster
//            at CLK_DIV=2, instance B a 22x7 raster at CLK_DIV=1, SYNC_POL=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_param_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    vga_param_controller_if a_if ();
    vga_param_controller_if b_if ();

    // A: H 64+4+8+4=80, V 8+2+2+2=14, frame 80*14*2 = 2240 clks
    vga_param_controller #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(2),
        .CLK_DIV(2),   .SYNC_POL(0)
    ) dut_a (
        .clk_100Mhz (clk),
        .rst        (rst),
        .vga        (a_if)
    );

    // B: H 16+2+2+2=22, V 4+1+1+1=7, frame 22*7 = 154 clks
    vga_param_controller #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1),   .SYNC_POL(1)
    ) dut_b (
        .clk_100Mhz (clk),
        .rst        (rst),
        .vga        (b_if)
    );

    task automatic step_a(input int pix);
        repeat (pix * 2) @(posedge clk);
        #1;
    endtask

    task automatic step_b(input int pix);
        repeat (pix) @(posedge clk);
        #1;
    endtask

    task automatic wait_fs_a(output int n);
        n = 0;
        while (n < 2600) begin
            @(posedge clk);
            #1;
            n++;
            if (a_if.frame_start === 1'b1) return;
        end
        n_total++;
        $display("FAIL fs_timeout_a: no frame_start within %0d clks", n);
        n = -1;
    endtask

    task automatic wait_fs_b(output int n);
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (b_if.frame_start === 1'b1) return;
        end
        n_total++;
        $display("FAIL fs_timeout_b: no frame_start within %0d clks", n);
        n = -1;
    endtask

    task automatic test_reset();
        int na;
        int nb;
        rst       = 1'b1;
        a_if.sw   = 8'h02;
        b_if.sw   = 8'h07;
        repeat (5) @(posedge clk);
        #1;
        n_total++;
        if (a_if.Hsync !== 1'b1 || a_if.Vsync !== 1'b1)
            $display("FAIL reset_sync_a: H=%b V=%b expected 1 1", a_if.Hsync, a_if.Vsync);
        else n_pass++;
        n_total++;
        if ({a_if.vgaRed, a_if.vgaGreen, a_if.vgaBlue} !== 12'h000)
            $display("FAIL reset_rgb_a: got %h expected 000",
                     {a_if.vgaRed, a_if.vgaGreen, a_if.vgaBlue});
        else n_pass++;
        n_total++;
        if (a_if.video_on !== 1'b0 || a_if.frame_start !== 1'b0)
            $display("FAIL reset_flags_a: von=%b fs=%b expected 0 0", a_if.video_on, a_if.frame_start);
        else n_pass++;
        n_total++;
        if (b_if.Hsync !== 1'b0 || b_if.Vsync !== 1'b0)
            $display("FAIL reset_sync_b: H=%b V=%b expected 0 0", b_if.Hsync, b_if.Vsync);
        else n_pass++;
        n_total++;
        if ({b_if.vgaRed, b_if.vgaGreen, b_if.vgaBlue} !== 12'h000 || b_if.video_on !== 1'b0)
            $display("FAIL reset_out_b: rgb=%h von=%b expected 000 0",
                     {b_if.vgaRed, b_if.vgaGreen, b_if.vgaBlue}, b_if.video_on);
        else n_pass++;

        @(negedge clk);
        rst = 1'b0;
        na  = -1;
        nb  = -1;
        for (int i = 1; i <= 3000 && na < 0; i++) begin
            @(posedge clk);
            #1;
            if (b_if.frame_start === 1'b1 && nb < 0) nb = i;
            if (a_if.frame_start === 1'b1) na = i;
        end
        n_total++;
        if (na != 2240) $display("FAIL first_fs_a: got %0d clks expected 2240", na);
        else n_pass++;
        n_total++;
        if (nb != 154) $display("FAIL first_fs_b: got %0d clks expected 154", nb);
        else n_pass++;
    endtask

    task automatic test_solid_blue();
        int          hs[6] = '{0, 63, 64, 79, 10, 10};
        int          vs[6] = '{0, 0, 0, 3, 7, 8};
        logic [11:0] exp_rgb[6] = '{12'h00F, 12'h00F, 12'h000, 12'h000, 12'h00F, 12'h000};
        logic        exp_von[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [11:0] got;
        int          pos;
        int          tgt;
        int          n;
        a_if.sw = 8'h02;
        wait_fs_a(n);
        pos = -1;
        for (int i = 0; i < 6; i++) begin
            tgt = vs[i] * 80 + hs[i];
            step_a(tgt - pos);
            pos = tgt;
            got = {a_if.vgaRed, a_if.vgaGreen, a_if.vgaBlue};
            n_total++;
            if (got !== exp_rgb[i] || a_if.video_on !== exp_von[i])
                $display("FAIL solid_blue(%0d,%0d): rgb=%h von=%b expected rgb=%h von=%b",
                         hs[i], vs[i], got, a_if.video_on, exp_rgb[i], exp_von[i]);
            else n_pass++;
        end
        wait_fs_a(n);
        n_total++;
        if (n < 0 || 2 * (pos + 1) + n != 2240)
            $display("FAIL frame_period_a: got %0d clks expected 2240", 2 * (pos + 1) + n);
        else n_pass++;
    endtask

    task automatic test_sync();
        logic exp_h;
        logic exp_v;
        int   n;
        wait_fs_a(n);
        for (int h = 0; h < 80; h++) begin
            step_a(1);
            exp_h = (h >= 68 && h < 76) ? 1'b0 : 1'b1;
            n_total++;
            if (a_if.Hsync !== exp_h || a_if.Vsync !== 1'b1)
                $display("FAIL hsync(h=%0d): H=%b V=%b expected H=%b V=1",
                         h, a_if.Hsync, a_if.Vsync, exp_h);
            else n_pass++;
        end
        for (int v = 1; v < 13; v++) begin
            step_a(80);
            exp_v = (v == 10 || v == 11) ? 1'b0 : 1'b1;
            n_total++;
            if (a_if.Vsync !== exp_v || a_if.Hsync !== 1'b1)
                $display("FAIL vsync(v=%0d): V=%b H=%b expected V=%b H=1",
                         v, a_if.Vsync, a_if.Hsync, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_mode_switch();
        logic [11:0] bars[8] = '{12'hFFF, 12'hFF0, 12'hF0F, 12'hF00,
                                 12'h0FF, 12'h0F0, 12'h00F, 12'h000};
        logic [11:0] got;
        logic [11:0] exp;
        int          pos;
        int          tgt;
        int          n;
        a_if.sw = 8'h04;
        wait_fs_a(n);
        step_a(4 * 80 + 1);
        got = {a_if.vgaRed, a_if.vgaGreen, a_if.vgaBlue};
        n_total++;
        if (got !== 12'h0F0) $display("FAIL pre_switch(0,4): got %h expected 0F0", got);
        else n_pass++;
        a_if.sw = 8'h44;
        step_a(2 * 80);
        got = {a_if.vgaRed, a_if.vgaGreen, a_if.vgaBlue};
        n_total++;
        if (got !== 12'h0F0) $display("FAIL mid_frame_hold(0,6): got %h expected 0F0", got);
        else n_pass++;
        wait_fs_a(n);
        pos = -1;
        for (int k = 0; k < 8; k++) begin
            for (int e = 0; e < 2; e++) begin
                tgt = 80 + 8 * k + 7 * e;
                step_a(tgt - pos);
                pos = tgt;
`ifdef VGA_TESTPATTERN_EN
                exp = bars[k];
`else
                exp = 12'h0F0;
`endif
                got = {a_if.vgaRed, a_if.vgaGreen, a_if.vgaBlue};
                n_total++;
                if (got !== exp)
                    $display("FAIL bars(h=%0d,v=1): got %h expected %h", 8 * k + 7 * e, got, exp);
                else n_pass++;
            end
        end
    endtask

`ifdef VGA_TESTPATTERN_EN
    task automatic test_checker();
        int          hs[5]  = '{0, 31, 32, 63, 64};
        logic [11:0] exp[5] = '{12'hF00, 12'hF00, 12'hFFF, 12'hFFF, 12'h000};
        logic [11:0] got;
        int          pos;
        int          n;
        a_if.sw = 8'h81;
        wait_fs_a(n);
        pos = -1;
        for (int i = 0; i < 5; i++) begin
            step_a(160 + hs[i] - pos);
            pos = 160 + hs[i];
            got = {a_if.vgaRed, a_if.vgaGreen, a_if.vgaBlue};
            n_total++;
            if (got !== exp[i])
                $display("FAIL checker(h=%0d,v=2): got %h expected %h", hs[i], got, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_moving();
        int          hs[6] = '{15, 16, 31, 32, 47, 48};
        logic [11:0] got;
        logic [11:0] exp;
        int          pos;
        int          n;
        rst     = 1'b1;
        a_if.sw = 8'hC0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int f = 1; f <= 2; f++) begin
            wait_fs_a(n);
            pos = -1;
            for (int i = 0; i < 6; i++) begin
                step_a(hs[i] - pos);
                pos = hs[i];
                exp = (hs[i] / 16 == f) ? 12'hFFF : 12'h000;
                got = {a_if.vgaRed, a_if.vgaGreen, a_if.vgaBlue};
                n_total++;
                if (got !== exp)
                    $display("FAIL moving(frame=%0d,h=%0d): got %h expected %h", f, hs[i], got, exp);
                else n_pass++;
            end
        end
    endtask
`endif

    task automatic test_rst_midframe();
        int n;
        a_if.sw = 8'h02;
        wait_fs_a(n);
        step_a(5 * 80 + 30 + 1);
        n_total++;
        if (a_if.vgaBlue !== 4'hF || a_if.video_on !== 1'b1)
            $display("FAIL pre_rst(30,5): blue=%h von=%b expected F 1", a_if.vgaBlue, a_if.video_on);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (a_if.vgaBlue !== 4'h0 || a_if.video_on !== 1'b0 || a_if.frame_start !== 1'b0)
            $display("FAIL rst_async_out: blue=%h von=%b fs=%b expected 0 0 0",
                     a_if.vgaBlue, a_if.video_on, a_if.frame_start);
        else n_pass++;
        n_total++;
        if (a_if.Hsync !== 1'b1 || a_if.Vsync !== 1'b1)
            $display("FAIL rst_async_sync: H=%b V=%b expected 1 1", a_if.Hsync, a_if.Vsync);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_fs_a(n);
        n_total++;
        if (n != 2240) $display("FAIL rst_first_fs: got %0d clks expected 2240", n);
        else n_pass++;
        wait_fs_a(n);
        n_total++;
        if (n != 2240) $display("FAIL rst_period: got %0d clks expected 2240", n);
        else n_pass++;
    endtask

    task automatic test_small_b();
        logic prev;
        int   t0;
        int   per;
        int   n;
        b_if.sw = 8'h07;
        prev    = b_if.Hsync;
        t0      = -1;
        per     = -1;
        for (int i = 0; i < 200 && per < 0; i++) begin
            @(posedge clk);
            #1;
            if (prev === 1'b0 && b_if.Hsync === 1'b1) begin
                if (t0 < 0) t0 = i;
                else per = i - t0;
            end
            prev = b_if.Hsync;
        end
        n_total++;
        if (per != 22) $display("FAIL line_period_b: got %0d clks expected 22", per);
        else n_pass++;

        wait_fs_b(n);
        step_b(1);
        n_total++;
        if (b_if.Vsync !== 1'b0 || b_if.video_on !== 1'b1 ||
            {b_if.vgaRed, b_if.vgaGreen, b_if.vgaBlue} !== 12'hFFF)
            $display("FAIL b_pix(0,0): V=%b von=%b rgb=%h expected 0 1 FFF", b_if.Vsync,
                     b_if.video_on, {b_if.vgaRed, b_if.vgaGreen, b_if.vgaBlue});
        else n_pass++;
        step_b(16);
        n_total++;
        if (b_if.video_on !== 1'b0 || {b_if.vgaRed, b_if.vgaGreen, b_if.vgaBlue} !== 12'h000)
            $display("FAIL b_pix(16,0): von=%b rgb=%h expected 0 000", b_if.video_on,
                     {b_if.vgaRed, b_if.vgaGreen, b_if.vgaBlue});
        else n_pass++;
        step_b(2);
        n_total++;
        if (b_if.Hsync !== 1'b1) $display("FAIL b_hsync(18,0): got %b expected 1", b_if.Hsync);
        else n_pass++;
        step_b(2);
        n_total++;
        if (b_if.Hsync !== 1'b0) $display("FAIL b_hsync(20,0): got %b expected 0", b_if.Hsync);
        else n_pass++;
        step_b(110);
        n_total++;
        if (b_if.Vsync !== 1'b1) $display("FAIL b_vsync(20,5): got %b expected 1", b_if.Vsync);
        else n_pass++;
        step_b(22);
        n_total++;
        if (b_if.Vsync !== 1'b0) $display("FAIL b_vsync(20,6): got %b expected 0", b_if.Vsync);
        else n_pass++;
        wait_fs_b(n);
        n_total++;
        if (n < 0 || 153 + n != 154)
            $display("FAIL frame_period_b: got %0d clks expected 154", 153 + n);
        else n_pass++;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_if.sw = 8'h00;
        b_if.sw = 8'h00;
        test_reset();
        test_solid_blue();
        test_sync();
        test_mode_switch();
`ifdef VGA_TESTPATTERN_EN
        test_checker();
        test_moving();
`endif
        test_rst_midframe();
        test_small_b();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
